// File: rtl/bp_be_dcache_wbuf_drain.sv
// Drains the dcache write buffer into data-mem bank writes through a one-entry issue register.
// Also runs the fence/flush drain handshake that waits until the buffer and the stage are empty.
module bp_be_dcache_wbuf_drain #(
    parameter int data_width_p  = 64,
    parameter int paddr_width_p = 56,
    parameter int ways_p        = 8,
    parameter int sets_p        = 64,
    localparam int mask_width_lp  = data_width_p / 8,
    localparam int lg_ways_lp     = $clog2(ways_p),
    localparam int lg_sets_lp     = $clog2(sets_p),
    localparam int entry_width_lp = paddr_width_p + lg_ways_lp
                                  + data_width_p + mask_width_lp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      wbuf_v_i,
    input  logic [entry_width_lp-1:0] wbuf_entry_i,
    input  logic                      wbuf_empty_i,
    output logic                      wbuf_yumi_o,
    output logic                      dm_v_o,
    output logic [lg_ways_lp-1:0]     dm_bank_o,
    output logic [lg_sets_lp-1:0]     dm_index_o,
    output logic [data_width_p-1:0]   dm_data_o,
    output logic [mask_width_lp-1:0]  dm_mask_o,
    input  logic                      dm_yumi_i,
    input  logic                      hold_i,
    input  logic                      drain_req_i,
    output logic                      drain_done_o,
    input  logic                      drain_ack_i,
    output logic                      busy_o
);

    localparam int byte_off_lp = $clog2(mask_width_lp);
    localparam int blk_off_lp  = lg_ways_lp + byte_off_lp;
    localparam int idx_top_lp  = blk_off_lp + lg_sets_lp;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                    r_state;
    logic                      r_done;
    logic                      r_stage_v;
    logic [lg_ways_lp-1:0]     r_bank;
    logic [lg_sets_lp-1:0]     r_index;
    logic [data_width_p-1:0]   r_data;
    logic [mask_width_lp-1:0]  r_mask;

    logic [mask_width_lp-1:0]  w_mask;
    logic [data_width_p-1:0]   w_data;
    logic [lg_ways_lp-1:0]     w_way;
    logic [paddr_width_p-1:0]  w_paddr;
    logic [lg_sets_lp-1:0]     w_index;
    logic [lg_ways_lp-1:0]     w_word;
    logic [lg_ways_lp-1:0]     w_bank;
    logic                      w_stage_free;
    logic                      w_pop_ok;
    logic                      w_pop;
    logic                      w_all_empty;
    logic                      w_unused;

    // Entry layout, MSB first: {paddr, way_id, data, mask}
    assign w_mask  = wbuf_entry_i[0 +: mask_width_lp];
    assign w_data  = wbuf_entry_i[mask_width_lp +: data_width_p];
    assign w_way   = wbuf_entry_i[mask_width_lp+data_width_p +: lg_ways_lp];
    assign w_paddr = wbuf_entry_i[mask_width_lp+data_width_p+lg_ways_lp +: paddr_width_p];

    // Words are striped across banks by way so one block spreads over all banks
    assign w_index = w_paddr[blk_off_lp +: lg_sets_lp];
    assign w_word  = w_paddr[byte_off_lp +: lg_ways_lp];
    assign w_bank  = w_word ^ w_way;

    assign w_unused = ^{w_paddr[paddr_width_p-1:idx_top_lp],
                        w_paddr[byte_off_lp-1:0]};

    assign w_stage_free = ~r_stage_v | (r_stage_v & dm_yumi_i);
    assign w_pop_ok     = (r_state == S_DRAIN) ? 1'b1 : ~hold_i;
    assign w_pop        = ~reset_i & wbuf_v_i & w_stage_free & w_pop_ok;
    assign w_all_empty  = wbuf_empty_i & ~r_stage_v & ~wbuf_v_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stage_v <= 1'b0;
            r_bank    <= '0;
            r_index   <= '0;
            r_data    <= '0;
            r_mask    <= '0;
        end else if (w_pop) begin
            r_stage_v <= 1'b1;
            r_bank    <= w_bank;
            r_index   <= w_index;
            r_data    <= w_data;
            r_mask    <= w_mask;
        end else if (dm_yumi_i) begin
            r_stage_v <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (drain_req_i) begin
                        if (w_all_empty) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_all_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (drain_ack_i) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign wbuf_yumi_o  = w_pop;
    assign dm_v_o       = r_stage_v;
    assign dm_bank_o    = r_bank;
    assign dm_index_o   = r_index;
    assign dm_data_o    = r_data;
    assign dm_mask_o    = r_mask;
    assign drain_done_o = r_done;
    assign busy_o       = r_stage_v;

`ifndef SYNTHESIS
    a_yumi_has_v: assert property (@(posedge clk_i) wbuf_yumi_o |-> wbuf_v_i);

    a_drain_moves: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == S_DRAIN && dm_v_o && dm_yumi_i && !wbuf_yumi_o) |=> !r_stage_v);
`endif

endmodule

// File: tb/tb_bp_be_dcache_wbuf_drain.sv
// Directed vector bench for the wbuf drain stage: issue, backpressure, hold, drain and reset.
module tb_bp_be_dcache_wbuf_drain;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         wbuf_v_i;
    logic [130:0] wbuf_entry_i;
    logic         wbuf_empty_i;
    logic         wbuf_yumi_o;
    logic         dm_v_o;
    logic [2:0]   dm_bank_o;
    logic [5:0]   dm_index_o;
    logic [63:0]  dm_data_o;
    logic [7:0]   dm_mask_o;
    logic         dm_yumi_i;
    logic         hold_i;
    logic         drain_req_i;
    logic         drain_done_o;
    logic         drain_ack_i;
    logic         busy_o;

    bp_be_dcache_wbuf_drain dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .wbuf_v_i     (wbuf_v_i),
        .wbuf_entry_i (wbuf_entry_i),
        .wbuf_empty_i (wbuf_empty_i),
        .wbuf_yumi_o  (wbuf_yumi_o),
        .dm_v_o       (dm_v_o),
        .dm_bank_o    (dm_bank_o),
        .dm_index_o   (dm_index_o),
        .dm_data_o    (dm_data_o),
        .dm_mask_o    (dm_mask_o),
        .dm_yumi_i    (dm_yumi_i),
        .hold_i       (hold_i),
        .drain_req_i  (drain_req_i),
        .drain_done_o (drain_done_o),
        .drain_ack_i  (drain_ack_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         rst;
        logic         v;
        logic [130:0] ent;
        logic         empty;
        logic         dy;
        logic         hold;
        logic         req;
        logic         ack;
        logic         e_yumi;
        logic         e_dmv;
        logic         e_done;
        logic         e_busy;
        logic         chkd;
        logic [2:0]   e_bank;
        logic [5:0]   e_idx;
        logic [63:0]  e_data;
        logic [7:0]   e_mask;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [130:0] pk(logic [55:0] pa, logic [2:0] w,
                                        logic [63:0] d, logic [7:0] m);
        return {pa, w, d, m};
    endfunction

    function automatic vec_t mk(
        logic rst, logic v, logic [130:0] ent, logic empty, logic dy,
        logic hold, logic req, logic ack,
        logic yumi, logic dmv, logic done, logic busy, logic chkd,
        logic [2:0] bank, logic [5:0] idx, logic [63:0] data, logic [7:0] mask);
        vec_t t;
        t.rst = rst; t.v = v; t.ent = ent; t.empty = empty; t.dy = dy;
        t.hold = hold; t.req = req; t.ack = ack;
        t.e_yumi = yumi; t.e_dmv = dmv; t.e_done = done; t.e_busy = busy;
        t.chkd = chkd; t.e_bank = bank; t.e_idx = idx;
        t.e_data = data; t.e_mask = mask;
        return t;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // A: word 1 ^ way 3 -> bank 2, index 1
    // B: word 7 ^ way 6 -> bank 1, index 0x3D
    // C: word 6 ^ way 0 -> bank 6, index 0x3F, zero mask
    logic [130:0] EA, EB, EC;
    logic [130:0] q [$];
    logic [2:0]  wb [3];
    logic [5:0]  wi [3];
    logic [63:0] wd [3];
    logic [7:0]  wm [3];

    initial begin
        EA = pk(56'h1048, 3'd3, 64'hDEAD, 8'h0F);
        EB = pk(56'h2F78, 3'd6, 64'h1111_2222_3333_4444, 8'hFF);
        EC = pk(56'h0FF0, 3'd0, 64'hCAFE, 8'h00);

        tv[0]  = mk(0,0,0 ,1,0,0,0,0, 0,0,0,0,1, 0,0,0,0);
        tv[1]  = mk(0,1,EA,0,1,0,0,0, 1,0,0,0,0, 0,0,0,0);
        tv[2]  = mk(0,0,0 ,1,1,0,0,0, 0,1,0,1,1, 3'd2,6'h01,64'hDEAD,8'h0F);
        tv[3]  = mk(0,0,0 ,1,1,0,0,0, 0,0,0,0,0, 0,0,0,0);
        tv[4]  = mk(0,1,EB,0,0,0,0,0, 1,0,0,0,0, 0,0,0,0);
        for (int i = 5; i <= 8; i++)
            tv[i] = mk(0,1,EC,0,0,0,0,0, 0,1,0,1,1,
                       3'd1,6'h3D,64'h1111_2222_3333_4444,8'hFF);
        tv[9]  = mk(0,1,EC,0,1,0,0,0, 1,1,0,1,1,
                    3'd1,6'h3D,64'h1111_2222_3333_4444,8'hFF);
        tv[10] = mk(0,0,0 ,1,1,0,0,0, 0,1,0,1,1, 3'd6,6'h3F,64'hCAFE,8'h00);
        tv[11] = mk(0,0,0 ,1,1,0,0,0, 0,0,0,0,0, 0,0,0,0);
        tv[12] = mk(0,1,EA,0,1,1,0,0, 0,0,0,0,0, 0,0,0,0);
        tv[13] = mk(0,1,EA,0,1,1,0,0, 0,0,0,0,0, 0,0,0,0);
        tv[14] = mk(0,1,EA,0,1,0,0,0, 1,0,0,0,0, 0,0,0,0);
        tv[15] = mk(0,0,0 ,1,0,1,0,0, 0,1,0,1,1, 3'd2,6'h01,64'hDEAD,8'h0F);
        tv[16] = mk(0,0,0 ,1,1,1,0,0, 0,1,0,1,1, 3'd2,6'h01,64'hDEAD,8'h0F);
        tv[17] = mk(0,0,0 ,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
        tv[18] = mk(0,0,0 ,1,0,0,1,0, 0,0,0,0,0, 0,0,0,0);
        tv[19] = mk(0,0,0 ,1,0,0,0,0, 0,0,1,0,0, 0,0,0,0);
        tv[20] = mk(0,0,0 ,1,0,0,0,0, 0,0,1,0,0, 0,0,0,0);
        tv[21] = mk(0,0,0 ,1,0,0,1,1, 0,0,1,0,0, 0,0,0,0);
        tv[22] = mk(0,0,0 ,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);
        tv[23] = mk(0,0,0 ,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0);

        reset_i = 1'b1; wbuf_v_i = 1'b0; wbuf_entry_i = '0;
        wbuf_empty_i = 1'b1; dm_yumi_i = 1'b0; hold_i = 1'b0;
        drain_req_i = 1'b0; drain_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i); #1;
            reset_i = tv[i].rst; wbuf_v_i = tv[i].v; wbuf_entry_i = tv[i].ent;
            wbuf_empty_i = tv[i].empty; dm_yumi_i = tv[i].dy; hold_i = tv[i].hold;
            drain_req_i = tv[i].req; drain_ack_i = tv[i].ack;
            #1;
            chk($sformatf("v%0d yumi", i), 64'(wbuf_yumi_o), 64'(tv[i].e_yumi));
            chk($sformatf("v%0d dm_v", i), 64'(dm_v_o), 64'(tv[i].e_dmv));
            chk($sformatf("v%0d done", i), 64'(drain_done_o), 64'(tv[i].e_done));
            chk($sformatf("v%0d busy", i), 64'(busy_o), 64'(tv[i].e_busy));
            if (tv[i].chkd) begin
                chk($sformatf("v%0d bank", i), 64'(dm_bank_o), 64'(tv[i].e_bank));
                chk($sformatf("v%0d index", i), 64'(dm_index_o), 64'(tv[i].e_idx));
                chk($sformatf("v%0d data", i), dm_data_o, tv[i].e_data);
                chk($sformatf("v%0d mask", i), 64'(dm_mask_o), 64'(tv[i].e_mask));
            end
        end

        // Drain with hold asserted: entries must still flow out
        begin
            int wr;
            bit got;
            wr = 0; got = 0;
            q = {EA, EB, EC};
            wb = '{3'd2, 3'd1, 3'd6};
            wi = '{6'h01, 6'h3D, 6'h3F};
            wd = '{64'hDEAD, 64'h1111_2222_3333_4444, 64'hCAFE};
            wm = '{8'h0F, 8'hFF, 8'h00};
            for (int c = 0; c < 20 && !got; c++) begin
                @(posedge clk_i); #1;
                wbuf_v_i = (q.size() > 0);
                wbuf_entry_i = (q.size() > 0) ? q[0] : '0;
                wbuf_empty_i = (q.size() == 0);
                dm_yumi_i = 1'b1; hold_i = 1'b1;
                drain_req_i = (c == 0); drain_ack_i = 1'b0;
                #1;
                if (c == 0)
                    chk("t4 hold blocks pop in idle", 64'(wbuf_yumi_o), 64'd0);
                if (dm_v_o && dm_yumi_i) begin
                    if (wr < 3) begin
                        chk($sformatf("t4 w%0d bank", wr), 64'(dm_bank_o), 64'(wb[wr]));
                        chk($sformatf("t4 w%0d index", wr), 64'(dm_index_o), 64'(wi[wr]));
                        chk($sformatf("t4 w%0d data", wr), dm_data_o, wd[wr]);
                        chk($sformatf("t4 w%0d mask", wr), 64'(dm_mask_o), 64'(wm[wr]));
                    end
                    wr++;
                end
                if (wbuf_yumi_o && q.size() > 0) void'(q.pop_front());
                if (drain_done_o) got = 1;
            end
            chk("t4 write count", 64'(wr), 64'd3);
            chk("t4 done reached", 64'(got), 64'd1);
            repeat (3) begin
                @(posedge clk_i); #1; #1;
                chk("t4 done held", 64'(drain_done_o), 64'd1);
            end
            @(posedge clk_i); #1 drain_ack_i = 1'b1; #1;
            chk("t4 done during ack", 64'(drain_done_o), 64'd1);
            @(posedge clk_i); #1 drain_ack_i = 1'b0; hold_i = 1'b0; #1;
            chk("t4 done after ack", 64'(drain_done_o), 64'd0);
        end

        // Reset while a write is stalled
        @(posedge clk_i); #1;
        wbuf_v_i = 1'b1; wbuf_entry_i = EA; wbuf_empty_i = 1'b0; dm_yumi_i = 1'b0;
        #1 chk("t6 pop", 64'(wbuf_yumi_o), 64'd1);
        @(posedge clk_i); #1 wbuf_entry_i = EB;
        #1 chk("t6 stalled dm_v", 64'(dm_v_o), 64'd1);
        @(posedge clk_i); #1 reset_i = 1'b1;
        #1 chk("t6 no pop in reset", 64'(wbuf_yumi_o), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0; wbuf_v_i = 1'b0; wbuf_empty_i = 1'b1; wbuf_entry_i = '0;
        #1;
        chk("t6 dm_v after reset", 64'(dm_v_o), 64'd0);
        chk("t6 busy after reset", 64'(busy_o), 64'd0);
        chk("t6 done after reset", 64'(drain_done_o), 64'd0);

        // Reset out of DONE clears drain_done_o
        @(posedge clk_i); #1 drain_req_i = 1'b1; #1;
        @(posedge clk_i); #1 drain_req_i = 1'b0;
        #1 chk("t6 done set", 64'(drain_done_o), 64'd1);
        @(posedge clk_i); #1 reset_i = 1'b1; #1;
        @(posedge clk_i); #1 reset_i = 1'b0;
        #1 chk("t6 done cleared by reset", 64'(drain_done_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
